// File: rtl/tlk2711_dma_rd_sched.sv
// tlk2711_dma_rd_sched
//   Drives the MM2S DataMover read-command channel for the TLK2711 transmit
//   path. A frame (DDR base, total bytes, chunk size) is split into 72-bit
//   read commands with at most MAX_OUTSTANDING issued but not yet completed.
//   DataMover statuses are checked for tag order and transfer errors; frame
//   completion is reported with a one-cycle o_done pulse.
//
// Ports
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_soft_rst         synchronous clear with the same effect as i_rst
//   i_start            one-cycle frame start (accepted only in IDLE)
//   i_base_addr        DDR start address, latched on accepted start
//   i_total_len        frame length in bytes, latched on accepted start
//   i_chunk_len        max bytes per command, latched on accepted start
//   o_cmd_data/valid   DataMover command, i_cmd_ready handshakes it
//   i_sts_data/valid   DataMover status {OKAY,SLVERR,DECERR,INTERR,TAG[3:0]}
//   o_sts_ready        high whenever not in reset
//   o_busy             frame in progress
//   o_done             one-cycle frame-complete pulse
//   o_status           [0] DMA error, [1] tag mismatch, [2] config error
//   o_chunk_cnt        statuses accepted in current/last frame (wraps)
module tlk2711_dma_rd_sched #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int BTT_W           = 23
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_soft_rst,
  input  logic             i_start,
  input  logic [31:0]      i_base_addr,
  input  logic [31:0]      i_total_len,
  input  logic [BTT_W-1:0] i_chunk_len,
  output logic [71:0]      o_cmd_data,
  output logic             o_cmd_valid,
  input  logic             i_cmd_ready,
  input  logic [7:0]       i_sts_data,
  input  logic             i_sts_valid,
  output logic             o_sts_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [3:0]       o_status,
  output logic [15:0]      o_chunk_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [31:0]      cur_addr;
  logic [31:0]      remaining;
  logic [BTT_W-1:0] chunk_len;
  logic [3:0]       outstanding;
  logic [3:0]       iss_idx;
  logic [3:0]       cmp_idx;

  function automatic logic [BTT_W-1:0] next_btt(input logic [31:0] rem,
                                                input logic [BTT_W-1:0] chunk);
    if (rem < 32'(chunk)) return rem[BTT_W-1:0];
    return chunk;
  endfunction

  function automatic logic [71:0] make_cmd(input logic [3:0] tag,
                                           input logic [31:0] addr,
                                           input logic [31:0] rem,
                                           input logic [BTT_W-1:0] chunk);
    logic eof;
    eof = (rem <= 32'(chunk));
    return {4'h0, tag, addr, 1'b0, eof, 6'h00, 1'b1, 23'(next_btt(rem, chunk))};
  endfunction

  // The presented command always describes {cur_addr, remaining}, so its
  // BTT can be recomputed here instead of being sliced back out of o_cmd_data.
  logic [BTT_W-1:0] cur_btt;
  logic             cmd_hs, sts_acc, sts_live, sts_orphan, sts_err, tag_err;
  logic [31:0]      addr_nx, rem_nx;
  logic [3:0]       iss_nx, outst_nx;
  logic [3:0]       status_nx;
  logic             err_nx, issue_nx;

  assign o_sts_ready = ~(i_rst | i_soft_rst);

  assign cur_btt    = next_btt(remaining, chunk_len);
  assign cmd_hs     = o_cmd_valid & i_cmd_ready;
  assign sts_acc    = i_sts_valid & o_sts_ready;
  // A status with nothing outstanding cannot match any command: flag it.
  assign sts_live   = sts_acc & (outstanding != 4'd0);
  assign sts_orphan = sts_acc & (outstanding == 4'd0);
  assign sts_err    = sts_live & (~i_sts_data[7] | (|i_sts_data[6:4]));
  assign tag_err    = (sts_live & (i_sts_data[3:0] != cmp_idx)) | sts_orphan;
  assign addr_nx    = cmd_hs ? cur_addr + 32'(cur_btt) : cur_addr;
  assign rem_nx     = cmd_hs ? remaining - 32'(cur_btt) : remaining;
  assign iss_nx     = iss_idx + {3'b000, cmd_hs};
  assign outst_nx   = outstanding + {3'b000, cmd_hs} - {3'b000, sts_live};
  assign status_nx  = o_status | {2'b00, tag_err, sts_err};
  assign err_nx     = |status_nx[1:0];
  assign issue_nx   = (rem_nx != 32'd0) && (int'(outst_nx) < MAX_OUTSTANDING);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      cur_addr    <= '0;
      remaining   <= '0;
      chunk_len   <= '0;
      outstanding <= '0;
      iss_idx     <= '0;
      cmp_idx     <= '0;
      o_cmd_data  <= '0;
      o_cmd_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_status    <= '0;
      o_chunk_cnt <= '0;
    end else if (i_soft_rst) begin
      state       <= IDLE;
      cur_addr    <= '0;
      remaining   <= '0;
      chunk_len   <= '0;
      outstanding <= '0;
      iss_idx     <= '0;
      cmp_idx     <= '0;
      o_cmd_data  <= '0;
      o_cmd_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_status    <= '0;
      o_chunk_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            cur_addr    <= i_base_addr;
            remaining   <= i_total_len;
            chunk_len   <= i_chunk_len;
            outstanding <= '0;
            iss_idx     <= '0;
            cmp_idx     <= '0;
            o_chunk_cnt <= '0;
            if (i_total_len == 32'd0 || i_chunk_len == '0) begin
              state    <= DONE;
              o_done   <= 1'b1;
              o_busy   <= 1'b0;
              o_status <= 4'b0100;
            end else begin
              // First command goes out straight from the inputs so valid
              // rises the cycle after the start edge.
              state       <= RUN;
              o_busy      <= 1'b1;
              o_status    <= '0;
              o_cmd_valid <= 1'b1;
              o_cmd_data  <= make_cmd(4'd0, i_base_addr, i_total_len, i_chunk_len);
            end
          end
        end

        RUN: begin
          cur_addr    <= addr_nx;
          remaining   <= rem_nx;
          iss_idx     <= iss_nx;
          outstanding <= outst_nx;
          o_status    <= status_nx;
          if (sts_live) begin
            o_chunk_cnt <= o_chunk_cnt + 16'd1;
            cmp_idx     <= cmp_idx + 4'd1;
          end
          if (err_nx) begin
            state       <= DRAIN;
            o_cmd_valid <= 1'b0;
          end else if (rem_nx == 32'd0 && outst_nx == 4'd0) begin
            state       <= DONE;
            o_cmd_valid <= 1'b0;
            o_done      <= 1'b1;
            o_busy      <= 1'b0;
          end else begin
            // Without a handshake the inputs to make_cmd are unchanged, so a
            // stalled command stays stable.
            o_cmd_valid <= issue_nx;
            o_cmd_data  <= make_cmd(iss_nx, addr_nx, rem_nx, chunk_len);
          end
        end

        DRAIN: begin
          outstanding <= outst_nx;
          o_status    <= status_nx;
          if (sts_live) begin
            o_chunk_cnt <= o_chunk_cnt + 16'd1;
            cmp_idx     <= cmp_idx + 4'd1;
          end
          if (outst_nx == 4'd0) begin
            state  <= DONE;
            o_done <= 1'b1;
            o_busy <= 1'b0;
          end
        end

        default: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
